// File: rtl/clt_gauss.sv
// Central-limit Gaussian approximator: sums NSUM uniform words, removes the mean,
// and buffers the result in a 2-entry first-word-fall-through FIFO.
module clt_gauss #(
  parameter int W    = 32,
  parameter int NSUM = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   rnd,
  input  logic           rnd_vld,
  output logic           rnd_rdy,
  output logic [W+3:0]   gauss,
  output logic           gauss_vld,
  input  logic           gauss_rdy,
  output logic [31:0]    samples
);
  localparam int CW = $clog2(NSUM);
  localparam logic [CW-1:0] LAST   = CW'(NSUM - 1);
  localparam logic [W+3:0]  NS     = (W+4)'(NSUM);
  localparam logic [W+3:0]  OFFSET = NS << (W - 1);

  logic [W+3:0]  acc, sum, sample, fifo0, fifo1;
  logic [CW-1:0] cnt;
  logic [1:0]    occ;
  logic          last, in_xfer, out_xfer, push;

  assign last      = (cnt == LAST);
  // Only the final word of a group can stall; partial sums never need FIFO room.
  assign rnd_rdy   = !rst && !(last && occ == 2'd2);
  assign in_xfer   = rnd_vld && rnd_rdy;
  assign push      = in_xfer && last;
  assign gauss_vld = (occ != 2'd0);
  assign gauss     = fifo0;
  assign out_xfer  = gauss_vld && gauss_rdy;
  assign sum       = acc + {4'b0, rnd};
  assign sample    = sum - OFFSET;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (in_xfer) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo0   <= '0;
      fifo1   <= '0;
      occ     <= 2'd0;
      samples <= '0;
    end else begin
      if (out_xfer) samples <= samples + 32'd1;
      case ({push, out_xfer})
        2'b10: begin
          if (occ == 2'd0) fifo0 <= sample;
          else             fifo1 <= sample;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          fifo0 <= fifo1;
          occ   <= occ - 2'd1;
        end
        // Push and pop together only happen at occupancy 1: new sample replaces head.
        2'b11: fifo0 <= sample;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_clt_gauss.sv
// Bench for clt_gauss: queue-based reference model checked every cycle, plus
// directed literal checks for the documented corner cases.
module tb_clt_gauss;
  localparam int W = 32;
  localparam int NSUM = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rnd;
  logic        rnd_vld, rnd_rdy;
  logic [35:0] gauss;
  logic        gauss_vld, gauss_rdy;
  logic [31:0] samples;

  clt_gauss #(.W(W), .NSUM(NSUM)) dut (
    .clk(clk), .rst(rst), .rnd(rnd), .rnd_vld(rnd_vld), .rnd_rdy(rnd_rdy),
    .gauss(gauss), .gauss_vld(gauss_vld), .gauss_rdy(gauss_rdy), .samples(samples)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors = 0;
  int          words = 0;
  bit [31:0]   grp[$];
  logic [35:0] fq[$];
  logic [31:0] m_samples = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Group sum minus the mean, reduced to 36 bits.
  function automatic logic [35:0] model_sample(input bit [31:0] g[$]);
    longint s = 0;
    foreach (g[i]) s += longint'(g[i]);
    s -= longint'(NSUM) * (longint'(1) << 31);
    return s[35:0];
  endfunction

  // Model predicts the transfers of the coming rising edge from the stable inputs.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rdy", {63'b0, rnd_rdy}, 64'd0);
      chk("rst_vld", {63'b0, gauss_vld}, 64'd0);
      chk("rst_gauss", {28'b0, gauss}, 64'd0);
      chk("rst_samples", {32'b0, samples}, 64'd0);
      grp.delete();
      fq.delete();
      m_samples = 0;
    end else begin
      bit m_rdy;
      m_rdy = !(grp.size() == NSUM - 1 && fq.size() == 2);
      chk("rnd_rdy", {63'b0, rnd_rdy}, {63'b0, m_rdy});
      chk("gauss_vld", {63'b0, gauss_vld}, {63'b0, fq.size() != 0});
      if (fq.size() != 0) chk("gauss", {28'b0, gauss}, {28'b0, fq[0]});
      chk("samples", {32'b0, samples}, {32'b0, m_samples});
      if (gauss_rdy && fq.size() != 0) begin
        void'(fq.pop_front());
        m_samples = m_samples + 32'd1;
      end
      if (rnd_vld && m_rdy) begin
        grp.push_back(rnd);
        words++;
        if (grp.size() == NSUM) begin
          fq.push_back(model_sample(grp));
          grp.delete();
        end
      end
    end
  end

  // Present one word and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [31:0] w);
    bit r;
    rnd = w;
    rnd_vld = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      r = rnd_rdy;
      @(posedge clk);
      #1;
      if (r) return;
    end
    chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_n(input int n, input logic [31:0] w);
    for (int i = 0; i < n; i++) send(w);
  endtask

  initial begin
    bit [31:0]   zq[$];
    bit [31:0]   fq12[$];
    logic [31:0] s0;
    int          cyc;

    rst = 1'b1; rnd = '0; rnd_vld = 1'b0; gauss_rdy = 1'b0;
    for (int i = 0; i < NSUM; i++) begin zq.push_back(32'h0); fq12.push_back(32'hFFFF_FFFF); end
    chk("pin_zero", {28'b0, model_sample(zq)}, 64'h0000_000A_0000_0000);
    chk("pin_ones", {28'b0, model_sample(fq12)}, 64'h0000_0005_FFFF_FFF4);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("first_rdy", {63'b0, rnd_rdy}, 64'd1);
    @(posedge clk); #1;

    // All-zero words: latency one cycle after the 12th accept.
    gauss_rdy = 1'b1;
    send_n(NSUM, 32'h0);
    rnd_vld = 1'b0;
    @(negedge clk);
    chk("zero_vld", {63'b0, gauss_vld}, 64'd1);
    chk("zero_gauss", {28'b0, gauss}, 64'h0000_000A_0000_0000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_samples", {32'b0, samples}, 64'd1);
    @(posedge clk); #1;

    send_n(NSUM, 32'h8000_0000);
    rnd_vld = 1'b0;
    @(negedge clk);
    chk("mid_gauss", {28'b0, gauss}, 64'd0);
    @(posedge clk); #1;

    send_n(NSUM, 32'hFFFF_FFFF);
    rnd_vld = 1'b0;
    @(negedge clk);
    chk("max_gauss", {28'b0, gauss}, 64'h0000_0005_FFFF_FFF4);
    @(posedge clk); #1;

    // Backpressure: two buffered samples stall the final word of the third.
    gauss_rdy = 1'b0;
    s0 = samples;
    send_n(3 * NSUM - 1, 32'h8000_0001);
    repeat (3) begin
      @(negedge clk);
      chk("bp_rdy", {63'b0, rnd_rdy}, 64'd0);
      chk("bp_head", {28'b0, gauss}, 64'd12);
    end
    @(posedge clk); #1;
    gauss_rdy = 1'b1;
    send(32'h8000_0001);
    rnd_vld = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp_pops", {32'b0, samples}, {32'b0, s0 + 32'd3});
    @(posedge clk); #1;

    // Reset mid-sample with one sample buffered.
    gauss_rdy = 1'b0;
    send_n(NSUM + 5, $urandom);
    rnd_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_rdy", {63'b0, rnd_rdy}, 64'd0);
    chk("arst_vld", {63'b0, gauss_vld}, 64'd0);
    chk("arst_gauss", {28'b0, gauss}, 64'd0);
    chk("arst_samples", {32'b0, samples}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    gauss_rdy = 1'b1;
    send_n(NSUM, 32'h8000_0000);
    rnd_vld = 1'b0;
    @(negedge clk);
    chk("post_rst_vld", {63'b0, gauss_vld}, 64'd1);
    chk("post_rst_gauss", {28'b0, gauss}, 64'd0);
    @(posedge clk); #1;

    // Random gaps on both sides.
    s0 = words;
    cyc = 0;
    while (words < s0 + 10000 && cyc < 60000) begin
      rnd = $urandom;
      rnd_vld = ($urandom_range(0, 3) != 0);
      gauss_rdy = $urandom_range(0, 1) == 1;
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_words", {63'b0, words >= s0 + 10000}, 64'd1);
    rnd_vld = 1'b0;
    gauss_rdy = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Counter wrap.
    gauss_rdy = 1'b0;
    force dut.samples = 32'hFFFF_FFFF;
    m_samples = 32'hFFFF_FFFF;
    #1 release dut.samples;
    send_n(NSUM, $urandom);
    rnd_vld = 1'b0;
    gauss_rdy = 1'b1;
    @(negedge clk);
    chk("wrap_pre", {32'b0, samples}, 64'h0000_0000_FFFF_FFFF);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap_post", {32'b0, samples}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
